seg_frame_capture: RTL and testbench

Synthesizable capture block for the multiplexed seven-segment bus that the top level drives (`seg_n`/`an_n`). It samples the scanned anode and segment lines and decodes each glyph back to a hex nibble. Each time a stable full frame changes, it publishes one 32-bit value with a valid/ack handshake. It closes the loop on the display path: benches and the on-board self-check compare CPU results without reading LEDs.

---
 rtl/seg_frame_capture.sv | 118 +++++++++++
 tb/tb_seg_frame_capture.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg_frame_capture.sv
// seg_frame_capture: samples the scanned seven-segment bus, decodes glyphs to nibbles
// and publishes each new stable 32-bit frame through a valid/ack handshake.
module seg_frame_capture #(
    parameter int DIGITS        = 8,
    parameter int SETTLE        = 4,
    parameter int STABLE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_n,
    input  logic [7:0]  an_n,
    output logic [31:0] value,
    output logic [7:0]  dp,
    output logic        frame_vld,
    input  logic        frame_ack,
    output logic        bad_glyph,
    output logic        bad_anode,
    output logic        overrun
);
    localparam int CW = $clog2(SETTLE + 1);
    localparam int MW = $clog2(STABLE_FRAMES + 1);
    localparam int MASK_I = (1 << DIGITS) - 1;
    localparam logic [7:0] MASK = MASK_I[7:0];

    logic [7:0]    seg_q, an_q, lows, seen, work_dp;
    logic [31:0]   work_val;
    logic [39:0]   cand;
    logic [CW-1:0] cnt;
    logic [MW-1:0] mc, mc_nxt;
    logic [2:0]    idx;
    logic [3:0]    nib;
    logic          ok, changed, sample, multi, take, full, same, qualify, ack_now, pub_once;

    assign changed = {seg_n, an_n} != {seg_q, an_q};
    // sample exactly once, on the edge where the counter reaches SETTLE
    assign sample  = !changed && cnt == CW'(SETTLE - 1);
    assign lows    = ~an_q;
    assign multi   = (lows & (lows - 8'd1)) != 8'd0;
    assign take    = sample && !multi && (lows & MASK) != 8'd0;
    assign full    = seen == MASK;
    assign same    = {work_val, work_dp} == cand;
    assign mc_nxt  = same ? (mc == MW'(STABLE_FRAMES) ? mc : mc + MW'(1)) : MW'(1);
    assign qualify = full && mc_nxt == MW'(STABLE_FRAMES) && (!pub_once || {work_val, work_dp} != {value, dp});
    assign ack_now = frame_ack && frame_vld;

    always_comb begin
        idx = '0;
        for (int i = 0; i < 8; i++) idx = lows[i] ? 3'(i) : idx;
    end

    always_comb begin
        ok  = 1'b1;
        nib = 4'h0;
        case (seg_q[6:0])
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q     <= 8'hFF;
            an_q      <= 8'hFF;
            cnt       <= '0;
            seen      <= '0;
            work_val  <= '0;
            work_dp   <= '0;
            cand      <= '0;
            mc        <= '0;
            pub_once  <= 1'b0;
            value     <= '0;
            dp        <= '0;
            frame_vld <= 1'b0;
            bad_glyph <= 1'b0;
            bad_anode <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            seg_q <= seg_n;
            an_q  <= an_n;
            cnt   <= changed ? '0 : (cnt == CW'(SETTLE) ? cnt : cnt + CW'(1));
            if (sample && multi) bad_anode <= 1'b1;
            if (take && !ok) bad_glyph <= 1'b1;
            if (take && ok) begin
                work_val[{idx, 2'b00} +: 4] <= nib;
                work_dp[idx]                <= !seg_q[7];
                seen[idx]                   <= 1'b1;
            end
            if (full) begin
                cand <= {work_val, work_dp};
                mc   <= mc_nxt;
                seen <= '0;
            end
            if (ack_now) frame_vld <= 1'b0;
            // a pending frame blocks the load; the candidate retries on the next completion
            if (qualify && frame_vld && !ack_now) overrun <= 1'b1;
            else if (qualify) begin
                {value, dp} <= {work_val, work_dp};
                frame_vld   <= 1'b1;
                pub_once    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_frame_capture.sv
// tb_seg_frame_capture: directed scans of the seven-segment bus with hand-computed
// expected frames, flags and handshake behaviour.
module tb_seg_frame_capture;
    logic        clk = 1'b0, rst = 1'b1, frame_ack = 1'b0;
    logic [7:0]  seg_n = 8'hFF, an_n = 8'hFF;
    logic [31:0] value;
    logic [7:0]  dp;
    logic        frame_vld, bad_glyph, bad_anode, overrun, vld_d;
    int          checks = 0, errors = 0, rises = 0;

    seg_frame_capture dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n), .value(value), .dp(dp),
        .frame_vld(frame_vld), .frame_ack(frame_ack), .bad_glyph(bad_glyph),
        .bad_anode(bad_anode), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        vld_d <= frame_vld;
        if (frame_vld && !vld_d) rises <= rises + 1;
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic put(input logic [7:0] s, input logic [7:0] a, input int n);
        seg_n = s;
        an_n  = a;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [31:0] v, input logic [7:0] d, input int ghost, input int last);
        for (int i = 0; i < 8; i++) begin
            put({~d[i], glyph(v[4*i +: 4])}, ~(8'd1 << i), i == 7 ? last : 10);
            if (ghost != 0) put(8'h00, ~(8'd1 << i), 2);
        end
    endtask

    task automatic ack;
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({value, dp, frame_vld, bad_glyph, bad_anode, overrun} !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h/%b%b%b%b want all zero", value, dp, frame_vld, bad_glyph, bad_anode, overrun);
        end
    endtask

    task automatic test_clean_scan;
        repeat (3) scan(32'h1234ABCD, 8'h00, 0, 10);
        checks++;
        if (rises !== 1) begin errors++; $display("FAIL clean_rises: got %0d want 1", rises); end
        checks++;
        if (value !== 32'h1234ABCD) begin errors++; $display("FAIL clean_value: got %h want 1234abcd", value); end
        checks++;
        if (dp !== 8'h00 || frame_vld !== 1'b1) begin errors++; $display("FAIL clean_dp_vld: got %h/%b want 00/1", dp, frame_vld); end
        ack();
        checks++;
        if (frame_vld !== 1'b0) begin errors++; $display("FAIL clean_ack: got vld %b want 0", frame_vld); end
        repeat (2) scan(32'h1234ABCD, 8'h00, 0, 10);
        checks++;
        if (rises !== 1 || frame_vld !== 1'b0) begin errors++; $display("FAIL clean_no_republish: got rises %0d vld %b want 1/0", rises, frame_vld); end
    endtask

    task automatic test_value_change;
        scan(32'hDEADBEEF, 8'h08, 0, 10);
        checks++;
        if (rises !== 1 || frame_vld !== 1'b0 || value !== 32'h1234ABCD) begin
            errors++;
            $display("FAIL change_first_frame: got rises %0d vld %b value %h want 1/0/1234abcd", rises, frame_vld, value);
        end
        scan(32'hDEADBEEF, 8'h08, 0, 10);
        checks++;
        if (rises !== 2 || frame_vld !== 1'b1) begin errors++; $display("FAIL change_publish: got rises %0d vld %b want 2/1", rises, frame_vld); end
        checks++;
        if (value !== 32'hDEADBEEF || dp !== 8'h08) begin errors++; $display("FAIL change_value: got %h/%h want deadbeef/08", value, dp); end
        ack();
    endtask

    task automatic test_glitch;
        repeat (2) scan(32'h0F0F5A5A, 8'h00, 1, 10);
        checks++;
        if (value !== 32'h0F0F5A5A || dp !== 8'h00) begin errors++; $display("FAIL glitch_value: got %h/%h want 0f0f5a5a/00", value, dp); end
        checks++;
        if (bad_glyph !== 1'b0 || rises !== 3) begin errors++; $display("FAIL glitch_flags: got bad_glyph %b rises %0d want 0/3", bad_glyph, rises); end
        ack();
    endtask

    task automatic test_errors;
        checks++;
        if (bad_anode !== 1'b0) begin errors++; $display("FAIL anode_pre: got %b want 0", bad_anode); end
        put(8'hC0, 8'hFC, 6);
        checks++;
        if (bad_anode !== 1'b1 || bad_glyph !== 1'b0) begin errors++; $display("FAIL anode_flag: got %b/%b want 1/0", bad_anode, bad_glyph); end
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++) put({1'b1, i == 2 ? 7'h7F : glyph(4'h3)}, ~(8'd1 << i), 10);
        checks++;
        if (bad_glyph !== 1'b1 || rises !== 3 || frame_vld !== 1'b0) begin
            errors++;
            $display("FAIL bad_glyph_frame: got flag %b rises %0d vld %b want 1/3/0", bad_glyph, rises, frame_vld);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({value, dp, frame_vld, bad_glyph, bad_anode, overrun} !== 44'd0) begin
            errors++;
            $display("FAIL reset_pulse: got %h/%h/%b%b%b%b want all zero", value, dp, frame_vld, bad_glyph, bad_anode, overrun);
        end
    endtask

    task automatic test_overrun;
        repeat (2) scan(32'h11111111, 8'h00, 0, 10);
        checks++;
        if (frame_vld !== 1'b1 || value !== 32'h11111111) begin errors++; $display("FAIL ovr_first: got %b/%h want 1/11111111", frame_vld, value); end
        repeat (2) scan(32'h22222222, 8'h00, 0, 10);
        checks++;
        if (overrun !== 1'b1 || value !== 32'h11111111) begin errors++; $display("FAIL ovr_flag: got %b/%h want 1/11111111", overrun, value); end
        ack();
        checks++;
        if (frame_vld !== 1'b0) begin errors++; $display("FAIL ovr_ack: got vld %b want 0", frame_vld); end
        scan(32'h22222222, 8'h00, 0, 10);
        checks++;
        if (frame_vld !== 1'b1 || value !== 32'h22222222 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_retry: got %b/%h/%b want 1/22222222/1", frame_vld, value, overrun);
        end
        ack();
    endtask

    task automatic test_back_to_back;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) scan(32'h11111111, 8'h00, 0, 10);
        scan(32'h22222222, 8'h00, 0, 10);
        scan(32'h22222222, 8'h00, 0, 5);
        checks++;
        if (frame_vld !== 1'b1 || value !== 32'h11111111) begin errors++; $display("FAIL b2b_before: got %b/%h want 1/11111111", frame_vld, value); end
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        checks++;
        if (frame_vld !== 1'b1 || value !== 32'h22222222 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_publish: got %b/%h/%b want 1/22222222/0", frame_vld, value, overrun);
        end
        @(negedge clk);
        checks++;
        if (frame_vld !== 1'b1) begin errors++; $display("FAIL b2b_hold: got vld %b want 1", frame_vld); end
    endtask

    initial begin
        test_reset();
        test_clean_scan();
        test_value_change();
        test_glitch();
        test_errors();
        test_overrun();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
